// File: rtl/adc_cap_pkg.sv
// Shared types and helpers for the triggered ADC capture block.
// Holds the FSM state encoding, the edge-select constants and the crossing test.
package adc_cap_pkg;

  localparam int SAMPLE_W = 8;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    PRE_FILL,
    ARMED,
    POST,
    DONE
  } cap_state_e;

  // Threshold crossing between two consecutive samples x (earlier) and y (later).
  function automatic logic crossing(
    input logic [SAMPLE_W-1:0] x,
    input logic [SAMPLE_W-1:0] y,
    input logic [SAMPLE_W-1:0] lvl,
    input logic                edge_sel
  );
    logic hit;
    case (edge_sel)
      EDGE_RISE: hit = (x < lvl) && (y >= lvl);
      EDGE_FALL: hit = (x > lvl) && (y <= lvl);
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/cap_ram_sdp.sv
// Simple dual-port single-clock RAM with a registered read port.
// Written so synthesis maps it onto a block RAM.
module cap_ram_sdp #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(2**AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_trig_capture.sv
// One-shot triggered capture of the two-sample ADC word stream into a circular
// buffer, with pre-trigger depth and trigger-aligned readout.
module adc_trig_capture
  import adc_cap_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [DW-1:0]       din,
  input  logic                din_valid,
  input  logic                arm,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_edge,
  input  logic                force_trig,
  input  logic [AW-1:0]       pre_len,
  output logic                busy,
  output logic                done,
  output logic                trig_sub,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       rd_data,
  output logic                rd_valid
);

  localparam logic [AW-1:0] LAST_IDX = '1;
  localparam logic [AW-1:0] ONE      = 1;

  cap_state_e          state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       fill_cnt_q, fill_cnt_d;
  logic [AW-1:0]       pre_q, pre_d;
  logic [AW-1:0]       post_cnt_q, post_cnt_d;
  logic [AW-1:0]       trig_ptr_q, trig_ptr_d;
  logic [SAMPLE_W-1:0] prev_b_q, prev_b_d;
  logic                prev_valid_q, prev_valid_d;
  logic                trig_sub_q, trig_sub_d;
  logic                rd_valid_q, rd_valid_d;

  logic [SAMPLE_W-1:0] smp_a, smp_b;
  logic                capturing, wr_en, rd_fire;
  logic                ev_a, ev_b, trig_evt;
  logic [AW-1:0]       rd_phys;
  logic [DW-1:0]       ram_rdata;

  assign smp_a = din[2*SAMPLE_W-1:SAMPLE_W];
  assign smp_b = din[SAMPLE_W-1:0];

  // arm wins over everything in its cycle, so it also blocks the write and the read.
  assign capturing = state_q inside {PRE_FILL, ARMED, POST};
  assign wr_en     = capturing && din_valid && !arm;
  assign rd_fire   = (state_q == DONE) && rd_en && !arm;

  assign ev_a     = prev_valid_q && crossing(prev_b_q, smp_a, trig_level, trig_edge);
  assign ev_b     = crossing(smp_a, smp_b, trig_level, trig_edge);
  assign trig_evt = ev_a || ev_b || force_trig;

  // Oldest captured word sits pre_q words before the trigger word.
  assign rd_phys = trig_ptr_q - pre_q + rd_addr;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_cnt_d   = fill_cnt_q;
    pre_d        = pre_q;
    post_cnt_d   = post_cnt_q;
    trig_ptr_d   = trig_ptr_q;
    prev_b_d     = prev_b_q;
    prev_valid_d = prev_valid_q;
    trig_sub_d   = trig_sub_q;
    rd_valid_d   = rd_fire;

    if (arm) begin
      wr_ptr_d     = '0;
      fill_cnt_d   = '0;
      prev_valid_d = 1'b0;
      pre_d        = pre_len;
      state_d      = (pre_len == '0) ? ARMED : PRE_FILL;
    end else if (wr_en) begin
      wr_ptr_d     = wr_ptr_q + ONE;
      prev_b_d     = smp_b;
      prev_valid_d = 1'b1;
      case (state_q)
        PRE_FILL: begin
          fill_cnt_d = fill_cnt_q + ONE;
          if ((fill_cnt_q + ONE) == pre_q) state_d = ARMED;
        end
        ARMED: begin
          if (trig_evt) begin
            trig_ptr_d = wr_ptr_q;
            post_cnt_d = LAST_IDX - pre_q;
            trig_sub_d = !ev_a && ev_b;
            state_d    = (pre_q == LAST_IDX) ? DONE : POST;
          end
        end
        POST: begin
          post_cnt_d = post_cnt_q - ONE;
          if (post_cnt_q == ONE) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      fill_cnt_q   <= '0;
      pre_q        <= '0;
      post_cnt_q   <= '0;
      trig_ptr_q   <= '0;
      prev_valid_q <= 1'b0;
      trig_sub_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_cnt_q   <= fill_cnt_d;
      pre_q        <= pre_d;
      post_cnt_q   <= post_cnt_d;
      trig_ptr_q   <= trig_ptr_d;
      prev_valid_q <= prev_valid_d;
      trig_sub_q   <= trig_sub_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    prev_b_q <= prev_b_d;
  end

  cap_ram_sdp #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk_i  (sys_clk),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(din),
    .re_i   (rd_fire),
    .raddr_i(rd_phys),
    .rdata_o(ram_rdata)
  );

  assign busy     = capturing;
  assign done     = (state_q == DONE);
  assign trig_sub = trig_sub_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_adc_trig_capture.sv
// Bench for adc_trig_capture: capture scenarios from a vector table, then
// hand-written re-arm and reset sequences; readout checked through a scoreboard.
module tb_adc_trig_capture;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int BIG   = 1 << 30;

  logic          sys_clk, sys_rst;
  logic [15:0]   din;
  logic          din_valid, arm;
  logic [7:0]    trig_level;
  logic          trig_edge, force_trig;
  logic [AW-1:0] pre_len;
  logic          busy, done, trig_sub;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic          rd_valid;

  int total = 0;
  int bad   = 0;
  logic [15:0] hist[$];
  logic [15:0] sb[$];

  typedef struct {
    int          pre;
    logic [7:0]  lvl;
    logic        fall;
    int          pat;
    bit          gaps;
    int          fk;
    bit          fpre;
    int          exp_k;
    logic        exp_sub;
    logic [15:0] exp_word;
  } cap_vec_t;

  cap_vec_t vecs[4];

  adc_trig_capture #(.AW(AW), .DW(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .din       (din),
    .din_valid (din_valid),
    .arm       (arm),
    .trig_level(trig_level),
    .trig_edge (trig_edge),
    .force_trig(force_trig),
    .pre_len   (pre_len),
    .busy      (busy),
    .done      (done),
    .trig_sub  (trig_sub),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Word k of each stimulus pattern.
  function automatic logic [15:0] gen(input int pat, input int k);
    logic [13:0] kk;
    logic [15:0] w;
    kk = k[13:0];
    case (pat)
      0: w = {kk[6:0], 1'b0, kk[6:0], 1'b1};
      1: begin
        if (k < 10)       w = {4'h6, kk[3:0], 4'h7, kk[3:0]};
        else if (k == 10) w = 16'h5030;
        else              w = {kk[7:0], ~kk[7:0]};
      end
      2: begin
        if (k == 0)      w = 16'h8081;
        else if (k == 1) w = 16'h8283;
        else if (k == 2) w = 16'h7090;
        else             w = {kk[7:0], ~kk[7:0]};
      end
      default: w = {1'b0, kk[6:0] ^ 7'h2A, 1'b0, kk[13:7] ^ 7'h15};
    endcase
    return w;
  endfunction

  task automatic do_arm(input int pre, input logic [7:0] lvl, input logic fall, input bit with_rd);
    @(negedge sys_clk);
    pre_len    = pre[AW-1:0];
    trig_level = lvl;
    trig_edge  = fall;
    arm        = 1'b1;
    din        = 16'h00FF;
    din_valid  = 1'b1;
    rd_en      = with_rd;
    rd_addr    = '0;
    @(negedge sys_clk);
    arm       = 1'b0;
    din_valid = 1'b0;
    rd_en     = 1'b0;
    pre_len   = ~pre[AW-1:0];
    chk("arm_busy", busy, 1);
    chk("arm_done", done, 0);
    chk("arm_rd_valid", rd_valid, 0);
    hist.delete();
  endtask

  // Feeds pattern words until done rises or max_words valid words were sent.
  task automatic feed(input int pat, input bit gaps, input int fk, input bit fpre, input int max_words);
    int cyc;
    int k;
    logic [15:0] w;
    cyc = 0;
    forever begin
      @(negedge sys_clk);
      if (done === 1'b1 || hist.size() >= max_words) break;
      if (cyc > 3 * DEPTH + 100) begin
        total++;
        bad++;
        $display("FAIL feed_timeout: got no done after %0d cycles, want done", cyc);
        break;
      end
      if (gaps && (cyc % 3 == 2)) begin
        din        = 16'h00FF;
        din_valid  = 1'b0;
        force_trig = 1'b0;
      end else begin
        k          = hist.size();
        w          = gen(pat, k);
        din        = w;
        din_valid  = 1'b1;
        force_trig = (k == fk) || (fpre && k < fk);
        hist.push_back(w);
      end
      cyc++;
    end
    din_valid  = 1'b0;
    force_trig = 1'b0;
  endtask

  // Full buffer readout, back-to-back with periodic rd_en gaps, while din keeps coming.
  task automatic readout(input int base);
    int i;
    int cyc;
    logic [15:0] e;
    i   = 0;
    cyc = 0;
    while (i < DEPTH || sb.size() > 0) begin
      @(negedge sys_clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_valid", rd_valid, 1);
        chk($sformatf("rd_data[%0d]", i - 1), rd_data, e);
      end else begin
        chk("rd_valid_gap", rd_valid, 0);
      end
      din       = 16'h00FF ^ 16'(cyc);
      din_valid = 1'b1;
      if (i < DEPTH && (cyc % 5) != 4) begin
        rd_en   = 1'b1;
        rd_addr = i[AW-1:0];
        if (base + i < hist.size()) sb.push_back(hist[base + i]);
        else                        sb.push_back(16'hDEAD);
        i++;
      end else begin
        rd_en = 1'b0;
      end
      cyc++;
    end
    rd_en     = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic read1(input int idx, input logic [15:0] expv, input string nm);
    @(negedge sys_clk);
    rd_en   = 1'b1;
    rd_addr = idx[AW-1:0];
    @(negedge sys_clk);
    rd_en = 1'b0;
    chk({nm, "_valid"}, rd_valid, 1);
    chk(nm, rd_data, expv);
    @(negedge sys_clk);
    chk({nm, "_drop"}, rd_valid, 0);
  endtask

  initial begin
    vecs[0] = '{pre: 4, lvl: 8'h80, fall: 1'b0, pat: 0, gaps: 1'b1, fk: -1, fpre: 1'b0,
                exp_k: 64, exp_sub: 1'b0, exp_word: 16'h8081};
    vecs[1] = '{pre: 5, lvl: 8'h40, fall: 1'b1, pat: 1, gaps: 1'b0, fk: -1, fpre: 1'b0,
                exp_k: 10, exp_sub: 1'b1, exp_word: 16'h5030};
    vecs[2] = '{pre: 0, lvl: 8'hFF, fall: 1'b0, pat: 3, gaps: 1'b0, fk: 0, fpre: 1'b0,
                exp_k: 0, exp_sub: 1'b0, exp_word: 16'h2A15};
    vecs[3] = '{pre: DEPTH - 1, lvl: 8'hFF, fall: 1'b0, pat: 3, gaps: 1'b1, fk: DEPTH - 1, fpre: 1'b1,
                exp_k: DEPTH - 1, exp_sub: 1'b0, exp_word: 16'h5512};

    sys_rst    = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    arm        = 1'b0;
    trig_level = '0;
    trig_edge  = 1'b0;
    force_trig = 1'b0;
    pre_len    = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_sub", trig_sub, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    sys_rst = 1'b0;

    // Valid data while IDLE must not start anything.
    din       = 16'h7F80;
    din_valid = 1'b1;
    repeat (3) @(negedge sys_clk);
    din_valid = 1'b0;
    chk("idle_busy", busy, 0);

    for (int t = 0; t < 4; t++) begin
      do_arm(vecs[t].pre, vecs[t].lvl, vecs[t].fall, 1'b0);
      feed(vecs[t].pat, vecs[t].gaps, vecs[t].fk, vecs[t].fpre, BIG);
      chk($sformatf("v%0d_words", t), hist.size(), vecs[t].exp_k + DEPTH - vecs[t].pre);
      chk($sformatf("v%0d_done", t), done, 1);
      chk($sformatf("v%0d_busy", t), busy, 0);
      chk($sformatf("v%0d_trig_sub", t), trig_sub, vecs[t].exp_sub);
      readout(vecs[t].exp_k - vecs[t].pre);
      read1(vecs[t].pre, vecs[t].exp_word, $sformatf("v%0d_trig_word", t));
    end

    // Re-arm in the middle of POST; the last word written before it ends in B=0x7F.
    do_arm(0, 8'hFF, 1'b0, 1'b0);
    feed(3, 1'b0, 0, 1'b0, 20);
    chk("midpost_busy", busy, 1);
    chk("midpost_done", done, 0);
    @(negedge sys_clk);
    din       = 16'h107F;
    din_valid = 1'b1;
    do_arm(0, 8'h80, 1'b0, 1'b0);
    feed(2, 1'b0, -1, 1'b0, BIG);
    chk("rearm_words", hist.size(), 2 + DEPTH);
    chk("rearm_trig_sub", trig_sub, 1);
    readout(2);
    read1(0, 16'h7090, "rearm_trig_word");

    // arm together with rd_en in DONE, then reset while ARMED.
    do_arm(3, 8'h80, 1'b0, 1'b1);
    feed(0, 1'b0, -1, 1'b0, 6);
    chk("armed_busy", busy, 1);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_trig_sub", trig_sub, 0);
    chk("midrst_rd_data", rd_data, 0);
    @(negedge sys_clk);
    rd_en = 1'b1;
    @(negedge sys_clk);
    rd_en = 1'b0;
    chk("idle_rd_valid", rd_valid, 0);

    // Fresh capture after reset.
    do_arm(2, 8'hFF, 1'b0, 1'b0);
    feed(3, 1'b1, 2, 1'b0, BIG);
    chk("post_rst_words", hist.size(), DEPTH);
    chk("post_rst_trig_sub", trig_sub, 0);
    readout(0);
    read1(2, 16'h2815, "post_rst_trig_word");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_trig_capture.md
Name: adc_trig_capture

Overview:
- Sits directly downstream of the AD9481 input stage and consumes its 16-bit sys_clk-domain word stream. Each word holds two 8-bit samples: {sample A in [15:8] (earlier), sample B in [7:0] (later)}.
- Implements a one-shot oscilloscope-style capture with a level/edge trigger and programmable pre-trigger depth into a circular RAM.
- After capture, the buffer is read out in trigger-aligned order for the host/display logic.

Parameters:
- AW, 10, address width; buffer depth DEPTH = 2**AW words (2*DEPTH samples).
- DW, 16, word width; fixed at 2 x 8-bit samples, not to be overridden.

Ports:
- sys_clk  in  1  system clock (ADC clock / 2); the only clock.
- sys_rst  in  1  synchronous reset, active-high.
- din  in  16  sample word {A,B} from the ADC input stage.
- din_valid  in  1  din qualifier; words with din_valid=0 are neither written nor trigger-evaluated.
- arm  in  1  single-cycle pulse that starts a new capture.
- trig_level  in  8  unsigned (offset-binary) trigger threshold.
- trig_edge  in  1  0 = rising edge, 1 = falling edge.
- force_trig  in  1  forces a trigger event while ARMED.
- pre_len  in  AW  pre-trigger word count; sampled on arm.
- busy  out  1  high in PRE_FILL, ARMED and POST.
- done  out  1  high in DONE.
- trig_sub  out  1  1 = trigger sample was B, 0 = A (or forced).
- rd_en  in  1  read request; honoured only in DONE.
- rd_addr  in  AW  logical read index, 0 = oldest word.
- rd_data  out  16  read word.
- rd_valid  out  1  high one cycle after an honoured rd_en.

Behaviour:
- Reset values: busy=0, done=0, trig_sub=0, rd_valid=0, rd_data=0. State returns to IDLE and all pointers and counters clear.
- States: IDLE, PRE_FILL, ARMED, POST, DONE.
- arm in any state: wr_ptr=0, fill_cnt=0, prev_valid=0, latch pre_len into pre_q, then enter PRE_FILL (or ARMED directly if pre_len=0).
  - arm has priority over every other event that cycle, including rd_en (rd_valid stays 0).
- Every din_valid cycle in PRE_FILL, ARMED and POST:
  - RAM[wr_ptr] <= din; wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
  - prev_b <= din[7:0]; prev_valid <= 1.
- PRE_FILL: fill_cnt counts written words. When the write making fill_cnt == pre_q occurs, transition to ARMED next cycle. No trigger is evaluated in PRE_FILL.
- ARMED, per valid word, unsigned compares:
  - Rising crossing(x,y) = x < L && y >= L. Falling crossing(x,y) = x > L && y <= L.
  - evA = prev_valid && crossing(prev_b, A). evB = crossing(A, B).
  - Event = evA | evB | force_trig.
  - trig_sub = !evA && evB. Earliest sample wins; a forced trigger reports 0.
  - On event: trig_ptr <= wr_ptr of the current word (that word is written); post_cnt <= DEPTH-1-pre_q; transition to POST.
  - If post_cnt = 0, go directly to DONE.
  - force_trig outside ARMED is ignored.
- POST: each valid write decrements post_cnt. The write that brings it to 0 is the last one, and the next state is DONE.
  - Total written since trigger word = DEPTH-pre_q words; total buffer = DEPTH words.
- DONE: no writes; buffer is frozen until the next arm.
  - Readout mapping: phys = (trig_ptr - pre_q + rd_addr) mod DEPTH, computed with AW-bit wrap arithmetic.
  - The trigger word sits at logical index pre_q.
  - rd_en -> rd_data/rd_valid registered, 1-cycle latency, back-to-back reads allowed. rd_valid deasserts the cycle after rd_en drops.
- Boundary conditions:
  - pre_len = DEPTH-1: post_cnt=0, so the trigger word is the last word captured.
  - pre_len=0: first valid word may trigger via evB only, because prev_valid=0.
  - Wrap-around in ARMED is normal: the oldest pre-trigger data is overwritten.
  - A trigger in ARMED with fewer than pre_q words is impossible by construction.
- sys_rst mid-capture aborts to IDLE immediately; RAM contents are don't-care.
- RAM: simple dual-port, single clock, registered read (block-RAM inference).

Decomposition:
- Shared package adc_cap_pkg: state enum (IDLE, PRE_FILL, ARMED, POST, DONE), EDGE_RISE=0 / EDGE_FALL=1, sample width constant 8.
- Sub-module cap_ram_sdp (parameterised AW/DW, write port + registered read port). The FSM, trigger detector and address math stay in the top module.

Test Plan:
- Reset, then arm with pre_len=4, level=0x80, rising; feed ramp words {0x00,0x01},{0x02,0x03}...
  - Expect trigger at the word containing A=0x80 with trig_sub=0, done after DEPTH-4 more words.
  - Readout index 4 = {0x80,0x81}.
- Falling edge, level=0x40, words {0x50,0x30}: evB fires, trig_sub=1. Readout at index pre_len equals {0x50,0x30}.
- Cross-word crossing: prev B=0x7F, next A=0x80, rising, level 0x80 -> evA, trig_sub=0.
  - The same values with prev_valid=0 (first word after arm) -> no trigger.
- pre_len=0 and pre_len=DEPTH-1 with force_trig:
  - Done after exactly DEPTH and 1 valid words respectively.
  - The trigger word appears at index 0 and DEPTH-1 respectively.
- din_valid gaps in every state: counts are unaffected by invalid cycles, and the readout contains only valid words in order.
- arm asserted mid-POST plus simultaneous rd_en in DONE; sys_rst during ARMED:
  - Capture restarts.
  - rd_valid stays 0 on the arm cycle.
  - Reset drives busy=done=rd_valid=0 the next cycle.
